ecc_dual_mem_responder: RTL and testbench



---
 rtl/ecc_dual_mem_responder_if.sv | 26 ++
 rtl/ecc_dual_mem_responder.sv | 128 ++++++++++++
 tb/tb_ecc_dual_mem_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_dual_mem_responder_if.sv
// Request/response bus between the ECC bridge and the dual 16-bit memory responder.
interface ecc_dual_mem_responder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        cs_n;
  logic [0:15]       wdata_up;
  logic [0:15]       wdata_down;
  logic [0:15]       rdata_up;
  logic [0:15]       rdata_down;
  logic              rvalid;
  logic              init_done;

  modport master (
    output req_valid, we, addr, cs_n, wdata_up, wdata_down,
    input  req_ready, rdata_up, rdata_down, rvalid, init_done
  );

  modport slave (
    input  req_valid, we, addr, cs_n, wdata_up, wdata_down,
    output req_ready, rdata_up, rdata_down, rvalid, init_done
  );
endinterface

// File: rtl/ecc_dual_mem_responder.sv
// Dual 16-bit memory bank responder (up/down chips) with post-reset clear and fixed read latency.
// Optional FAULT_INJECT_EN adds fi_en/fi_mask to XOR read data per request.
module ecc_dual_mem_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RD_LAT   = 2,
  parameter logic [0:15] INIT_VAL = 16'h0000
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef FAULT_INJECT_EN
  input  logic                          fi_en,
  input  logic [0:31]                   fi_mask,
`endif
  ecc_dual_mem_responder_if.slave       bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              ready;

  logic [0:15] mem_up   [DEPTH];
  logic [0:15] mem_down [DEPTH];

  logic        acc, wr_acc, rd_acc;
  logic [0:31] acc_mask;
  logic [0:31] rd_word;

  logic        pv [RD_LAT];
  logic [0:31] pd [RD_LAT];
  logic [0:31] pm [RD_LAT];

  logic        rvalid_q;
  logic [0:15] rdata_up_q, rdata_down_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    ready   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        clr_d = clr_q + ADDR_W'(1);
        if (clr_q == '1) state_d = ST_READY;
      end
      ST_READY: ready = 1'b1;
      default:  state_d = ST_INIT;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.init_done = ready;

  assign acc    = bus.req_valid && ready;
  assign wr_acc = acc && bus.we;
  assign rd_acc = acc && !bus.we && (bus.cs_n != 2'b11);

`ifdef FAULT_INJECT_EN
  assign acc_mask = fi_en ? fi_mask : '0;
`else
  assign acc_mask = '0;
`endif

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_up[clr_q]   <= INIT_VAL;
        mem_down[clr_q] <= INIT_VAL;
      end else if (wr_acc) begin
        if (!bus.cs_n[1]) mem_up[bus.addr]   <= bus.wdata_up;
        if (!bus.cs_n[0]) mem_down[bus.addr] <= bus.wdata_down;
      end
    end
  end

  // Deselected bank reads as zero; both banks are sampled at the accept edge.
  assign rd_word = {bus.cs_n[1] ? 16'h0000 : mem_up[bus.addr],
                    bus.cs_n[0] ? 16'h0000 : mem_down[bus.addr]};

  // ---------------- read pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pv[i] <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_up_q   <= '0;
      rdata_down_q <= '0;
    end else begin
      pv[0] <= rd_acc;
      for (int unsigned i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
      rvalid_q <= pv[RD_LAT-1];
      if (pv[RD_LAT-1]) begin
        {rdata_up_q, rdata_down_q} <= pd[RD_LAT-1] ^ pm[RD_LAT-1];
      end
    end
  end

  // Payload stages need no reset: only the valid bits gate their use.
  always_ff @(posedge clk) begin
    pd[0] <= rd_word;
    pm[0] <= acc_mask;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pd[i] <= pd[i-1];
      pm[i] <= pm[i-1];
    end
  end

  assign bus.rvalid     = rvalid_q;
  assign bus.rdata_up   = rdata_up_q;
  assign bus.rdata_down = rdata_down_q;

endmodule

// File: tb/tb_ecc_dual_mem_responder.sv
// Randomized + directed bench for ecc_dual_mem_responder against a cycle-indexed behavioural model.
module tb_ecc_dual_mem_responder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fi_en = 1'b0;
  logic [31:0] fi_mask = '0;

  ecc_dual_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  ecc_dual_mem_responder #(
    .ADDR_W  (ADDR_W),
    .RD_LAT  (RD_LAT),
    .INIT_VAL(16'h0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef FAULT_INJECT_EN
    .fi_en  (fi_en),
    .fi_mask(fi_mask),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_up   [DEPTH];
  logic [15:0] ref_down [DEPTH];
  logic [31:0] last_data;
  int unsigned cyc = 0;
  int unsigned init_cnt = 0;
  logic        model_ready = 1'b0;
  int unsigned rv_pulses = 0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic observe();
    logic [31:0] got;
    got = {bus.rdata_up, bus.rdata_down};
    check("req_ready", 32'(bus.req_ready), 32'(model_ready));
    check("init_done", 32'(bus.init_done), 32'(model_ready));
    if (q.size() != 0 && q[0].due == cyc) begin
      check("rvalid_hi", 32'(bus.rvalid), 32'd1);
      check("rdata", got, q[0].data);
      last_data = q[0].data;
      void'(q.pop_front());
      if (bus.rvalid) rv_pulses++;
    end else begin
      check("rvalid_lo", 32'(bus.rvalid), 32'd0);
      check("rdata_hold", got, last_data);
    end
  endtask

  // Drives one request slot and advances the model and the clock by one cycle.
  task automatic tick(input logic v, input logic w, input logic [3:0] a, input logic [1:0] cs,
                      input logic [15:0] wu, input logic [15:0] wd,
                      input logic fe, input logic [31:0] fm);
    logic [31:0] rd;
    bus.req_valid  = v;
    bus.we         = w;
    bus.addr       = a;
    bus.cs_n       = cs;
    bus.wdata_up   = wu;
    bus.wdata_down = wd;
    fi_en          = fe;
    fi_mask        = fm;
    if (v && model_ready) begin
      if (w) begin
        if (!cs[1]) ref_up[a]   = wu;
        if (!cs[0]) ref_down[a] = wd;
      end else if (cs != 2'b11) begin
        rd = {cs[1] ? 16'h0000 : ref_up[a], cs[0] ? 16'h0000 : ref_down[a]};
`ifdef FAULT_INJECT_EN
        if (fe) rd = rd ^ fm;
`endif
        q.push_back('{due: cyc + 1 + RD_LAT, data: rd});
      end
    end
    if (init_cnt > 0) begin
      init_cnt--;
      model_ready = (init_cnt == 0);
    end
    @(posedge clk);
    cyc++;
    #1;
    observe();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, 2'b11, 16'h0, 16'h0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [1:0] cs);
    tick(1'b1, 1'b0, a, cs, 16'h0, 16'h0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] cs, input logic [15:0] wu, input logic [15:0] wd);
    tick(1'b1, 1'b1, a, cs, wu, wd, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int unsigned n);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    q.delete();
    model_ready = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ref_up[i]   = 16'h0000;
      ref_down[i] = 16'h0000;
    end
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    end
    check("rst_rdata", {bus.rdata_up, bus.rdata_down}, 32'h0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    rst       = 1'b0;
    last_data = '0;
    init_cnt  = DEPTH;
  endtask

  task automatic wait_init();
    int unsigned n;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      idle(1);
      n++;
    end
    check("init_len", n, DEPTH);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.we         = 1'b0;
    bus.addr       = '0;
    bus.cs_n       = 2'b11;
    bus.wdata_up   = '0;
    bus.wdata_down = '0;
    last_data      = '0;

    do_reset(3);
    wait_init();

    // cleared contents, codeword round trip, bypass isolation
    rd(4'd5, 2'b00);
    idle(3);
    wr(4'd3, 2'b00, 16'hA5C3, 16'h1E0F);
    rd(4'd3, 2'b00);
    idle(3);
    wr(4'd7, 2'b01, 16'hBEEF, 16'h1234);
    rd(4'd7, 2'b00);
    rd(4'd7, 2'b10);
    idle(3);

    // pipelined reads with a no-op slot
    rv_pulses = 0;
    rd(4'd0, 2'b00);
    rd(4'd1, 2'b00);
    rd(4'd2, 2'b11);
    rd(4'd2, 2'b00);
    rd(4'd3, 2'b00);
    idle(4);
    check("pipe_pulses", rv_pulses, 32'd4);

`ifdef FAULT_INJECT_EN
    tick(1'b1, 1'b0, 4'd3, 2'b00, 16'h0, 16'h0, 1'b1, 32'h80000001);
    rd(4'd3, 2'b00);
    idle(3);
`endif

    // reset with a read in flight, then the old data must be gone
    rd(4'd3, 2'b00);
    do_reset(2);
    wait_init();
    rd(4'd3, 2'b00);
    idle(3);

    // randomized traffic, including address-space edges
    for (int unsigned i = 0; i < 400; i++) begin
      logic v, w, fe;
      logic [3:0] a;
      logic [1:0] cs;
      v  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      a  = 4'($urandom_range(0, 15));
      cs = 2'($urandom_range(0, 3));
      fe = $urandom_range(0, 3) == 0;
      tick(v, w, a, cs, 16'($urandom), 16'($urandom), fe, $urandom);
      if (i == 200) begin
        do_reset(1);
        wait_init();
      end
    end
    idle(4);
    check("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
